// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the mips_muldiv multiply/divide unit.
// The divider path is present only when MULDIV_DIV_EN is defined.
package mips_muldiv_pkg;

  localparam int ITER_COUNT = 32;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE,
    RUN_MUL,
    RUN_DIV,
    FINISH
  } state_t;

  typedef enum logic {
    STEP_MUL,
    STEP_DIV
  } step_mode_t;

  // Signed operands are iterated on as magnitudes; the sign is fixed up at the end.
  function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
    return (is_signed && value[31]) ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the multiply (add-shift) or divide (subtract-restore-shift) datapath.
// The divide branch exists only when MULDIV_DIV_EN is defined.
module mips_muldiv_step
  import mips_muldiv_pkg::*;
(
  input  logic [63:0] acc_i,
  input  logic [31:0] operand_i,
  input  step_mode_t  mode_i,
  output logic [63:0] acc_o
);

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
`ifdef MULDIV_DIV_EN
  logic [32:0] rem_shift;
  logic [31:0] rem_diff;
  logic        rem_ge;
`endif

  // Multiply: upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  always_comb begin
    mul_sum  = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, operand_i} : 33'd0);
    mul_next = {mul_sum, acc_i[31:1]};
    acc_o    = acc_i;
    if (mode_i == STEP_MUL) begin
      acc_o = mul_next;
    end
`ifdef MULDIV_DIV_EN
    rem_shift = acc_i[63:31];
    rem_ge    = rem_shift >= {1'b0, operand_i};
    rem_diff  = rem_shift[31:0] - operand_i;
    if (mode_i == STEP_DIV) begin
      acc_o = rem_ge ? {rem_diff, acc_i[30:0], 1'b1}
                     : {rem_shift[31:0], acc_i[30:0], 1'b0};
    end
`endif
  end

endmodule

// File: rtl/mips_muldiv.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO registers and start/busy/done handshake.
// Define MULDIV_DIV_EN to include the iterative divider; otherwise DIV/DIVU leave HI/LO unchanged.
module mips_muldiv
  import mips_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
`ifdef MULDIV_DIV_EN
  logic        neg_rem_q, neg_rem_d;
  logic        dbz_q, dbz_d;
  logic [31:0] quot_fix, rem_fix;
`endif

  logic        is_mul_op, is_div_op, is_signed_op, is_mthi, is_mtlo, accept;
  logic [31:0] mag_a, mag_b;
  logic [63:0] prod_fix, step_acc;
  step_mode_t  step_mode;

  always_comb begin
    is_mul_op    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    is_div_op    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    is_signed_op = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    is_mthi      = funct == FUNCT_MTHI;
    is_mtlo      = funct == FUNCT_MTLO;
    accept       = start && (state_q == IDLE);
    step_mode    = (state_q == RUN_DIV) ? STEP_DIV : STEP_MUL;
  end

  mips_muldiv_step u_step (
    .acc_i     (acc_q),
    .operand_i (opb_q),
    .mode_i    (step_mode),
    .acc_o     (step_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= 5'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Counter runs ITER_COUNT-1 down to 0, one iteration per cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (accept && is_mul_op) begin
          state_d = RUN_MUL;
          count_d = 5'(ITER_COUNT - 1);
        end else if (accept && is_div_op) begin
`ifdef MULDIV_DIV_EN
          state_d = RUN_DIV;
          count_d = 5'(ITER_COUNT - 1);
`else
          state_d = FINISH;
`endif
        end
      end
      RUN_MUL, RUN_DIV: begin
        if (count_q == 5'd0) begin
          state_d = FINISH;
        end else begin
          count_d = count_q - 5'd1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= 64'd0;
      opb_q     <= 32'd0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
`endif
    end else begin
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
`ifdef MULDIV_DIV_EN
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
`endif
    end
  end

  always_comb begin
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    mag_a    = magnitude(rs_data, is_signed_op);
    mag_b    = magnitude(rt_data, is_signed_op);
    prod_fix = neg_q ? (~acc_q + 64'd1) : acc_q;
`ifdef MULDIV_DIV_EN
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    quot_fix  = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix   = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
`endif
    unique case (state_q)
      IDLE: begin
        if (accept && (is_mul_op || is_div_op)) begin
          acc_d    = {32'd0, mag_a};
          opb_d    = mag_b;
          is_div_d = is_div_op;
          neg_d    = is_signed_op && (rs_data[31] ^ rt_data[31]);
`ifdef MULDIV_DIV_EN
          neg_rem_d = is_signed_op && rs_data[31];
          dbz_d     = rt_data == 32'd0;
`endif
        end else if (accept && is_mthi) begin
          hi_d   = rs_data;
          done_d = 1'b1;
        end else if (accept && is_mtlo) begin
          lo_d   = rs_data;
          done_d = 1'b1;
        end
      end
      RUN_MUL, RUN_DIV: acc_d = step_acc;
      FINISH: begin
        done_d = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
`ifdef MULDIV_DIV_EN
        // A zero divisor leaves the remainder equal to the dividend; the quotient is forced to all ones.
        else begin
          hi_d = rem_fix;
          lo_d = dbz_q ? 32'hFFFF_FFFF : quot_fix;
        end
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = state_q != IDLE;
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv against an arithmetic reference model.
// Divide expectations follow MULDIV_DIV_EN the same way the design does.
module tb_mips_muldiv;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  always #5 clk = ~clk;

  mips_muldiv dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .funct   (funct),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  // Reference result {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] old_hi, input logic [31:0] old_lo);
    longint      sa, sb, sres, srem;
    logic [63:0] ures;
    logic [31:0] nh, nl;
    nh = old_hi;
    nl = old_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (f == F_MULT) begin
      sres = sa * sb;
      ures = sres;
      nh = ures[63:32];
      nl = ures[31:0];
    end else if (f == F_MULTU) begin
      ures = {32'd0, a} * {32'd0, b};
      nh = ures[63:32];
      nl = ures[31:0];
    end else if (f == F_MTHI) begin
      nh = a;
    end else if (f == F_MTLO) begin
      nl = a;
    end
`ifdef MULDIV_DIV_EN
    else if ((f == F_DIV || f == F_DIVU) && b == 32'd0) begin
      nl = 32'hFFFF_FFFF;
      nh = a;
    end else if (f == F_DIV) begin
      sres = sa / sb;
      srem = sa % sb;
      ures = sres;
      nl = ures[31:0];
      ures = srem;
      nh = ures[31:0];
    end else if (f == F_DIVU) begin
      nl = a / b;
      nh = a % b;
    end
`endif
    return {nh, nl};
  endfunction

  function automatic int exp_latency(input logic [5:0] f);
    if (f == F_MTHI || f == F_MTLO) return 0;
`ifndef MULDIV_DIV_EN
    if (f == F_DIV || f == F_DIVU) return 1;
`endif
    return 33;
  endfunction

  // Issue one operation and follow it until done; operands are scrambled right after the start edge.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles, output int done_edge, output logic done_next,
                        output logic [31:0] hi_at_done, output logic [31:0] lo_at_done);
    @(negedge clk);
    start = 1'b1;
    funct = f;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    busy_cycles = 0;
    done_edge = -1;
    hi_at_done = hi;
    lo_at_done = lo;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
      end
      if (busy) busy_cycles++;
      if (done) begin
        done_edge = k;
        hi_at_done = hi;
        lo_at_done = lo;
        break;
      end
    end
    @(negedge clk);
    done_next = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    funct = 6'd0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++; if (hi !== 32'd0) begin n_errors++; $display("[TB] FAIL reset_hi: got %h, expected %h", hi, 32'd0); end
    n_checks++; if (lo !== 32'd0) begin n_errors++; $display("[TB] FAIL reset_lo: got %h, expected %h", lo, 32'd0); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
    rst_n = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
  endtask

  task automatic test_directed();
    logic [5:0]  fs [9];
    logic [31:0] as [9];
    logic [31:0] bs [9];
    logic [63:0] exp;
    logic [31:0] h, l;
    int          bc, de;
    logic        dn;
    fs = '{F_MULTU, F_MULT, F_DIV, F_DIVU, F_DIVU, F_DIV, F_DIV, F_MULT, F_MTHI};
    as = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'd5,
           32'h8000_0000, 32'hFFFF_FFF7, 32'h8000_0000, 32'h1234_5678};
    bs = '{32'd2, 32'd7, 32'd2, 32'd7, 32'd0,
           32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'hDEAD_BEEF};
    for (int i = 0; i < 9; i++) begin
      exp = model(fs[i], as[i], bs[i], exp_hi, exp_lo);
      run_op(fs[i], as[i], bs[i], bc, de, dn, h, l);
      n_checks++; if (h !== exp[63:32]) begin n_errors++; $display("[TB] FAIL dir%0d_hi: got %h, expected %h", i, h, exp[63:32]); end
      n_checks++; if (l !== exp[31:0]) begin n_errors++; $display("[TB] FAIL dir%0d_lo: got %h, expected %h", i, l, exp[31:0]); end
      n_checks++; if (de != exp_latency(fs[i])) begin n_errors++; $display("[TB] FAIL dir%0d_done_edge: got %0d, expected %0d", i, de, exp_latency(fs[i])); end
      n_checks++; if (bc != exp_latency(fs[i])) begin n_errors++; $display("[TB] FAIL dir%0d_busy_cycles: got %0d, expected %0d", i, bc, exp_latency(fs[i])); end
      n_checks++; if (dn !== 1'b0) begin n_errors++; $display("[TB] FAIL dir%0d_done_width: got %b, expected 0", i, dn); end
      exp_hi = exp[63:32];
      exp_lo = exp[31:0];
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [6];
    logic [5:0]  f;
    logic [31:0] a, b, h, l;
    logic [63:0] exp;
    int          bc, de;
    logic        dn;
    ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
    for (int i = 0; i < 24; i++) begin
      f = ops[$urandom_range(0, 5)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      exp = model(f, a, b, exp_hi, exp_lo);
      run_op(f, a, b, bc, de, dn, h, l);
      n_checks++; if (h !== exp[63:32]) begin n_errors++; $display("[TB] FAIL rnd%0d_hi f=%b a=%h b=%h: got %h, expected %h", i, f, a, b, h, exp[63:32]); end
      n_checks++; if (l !== exp[31:0]) begin n_errors++; $display("[TB] FAIL rnd%0d_lo f=%b a=%h b=%h: got %h, expected %h", i, f, a, b, l, exp[31:0]); end
      n_checks++; if (de != exp_latency(f)) begin n_errors++; $display("[TB] FAIL rnd%0d_done_edge: got %0d, expected %0d", i, de, exp_latency(f)); end
      exp_hi = exp[63:32];
      exp_lo = exp[31:0];
    end
  endtask

  task automatic test_invalid_funct();
    logic saw_done, saw_busy;
    saw_done = 1'b0;
    saw_busy = 1'b0;
    @(negedge clk);
    start = 1'b1;
    funct = 6'b100000;
    rs_data = $urandom;
    rt_data = $urandom;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) start = 1'b0;
      if (done) saw_done = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_errors++; $display("[TB] FAIL invalid_done: got %b, expected 0", saw_done); end
    n_checks++; if (saw_busy !== 1'b0) begin n_errors++; $display("[TB] FAIL invalid_busy: got %b, expected 0", saw_busy); end
    n_checks++; if (hi !== exp_hi) begin n_errors++; $display("[TB] FAIL invalid_hi: got %h, expected %h", hi, exp_hi); end
    n_checks++; if (lo !== exp_lo) begin n_errors++; $display("[TB] FAIL invalid_lo: got %h, expected %h", lo, exp_lo); end
  endtask

  task automatic test_busy_drop();
    logic [31:0] a, b, a2, b2;
    logic [63:0] exp;
    int          de;
    logic        extra_done, extra_busy;
    a = $urandom;
    b = $urandom;
    a2 = $urandom;
    b2 = $urandom;
    exp = model(F_MULT, a, b, exp_hi, exp_lo);
    extra_done = 1'b0;
    extra_busy = 1'b0;
    de = -1;
    @(negedge clk);
    start = 1'b1;
    funct = F_MULT;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 9) begin start = 1'b1; funct = F_MULTU; rs_data = a2; rt_data = b2; end
      if (k == 10) start = 1'b0;
      if (k == 32) begin start = 1'b1; funct = F_MTHI; rs_data = a2; end
      if (done) begin de = k; break; end
    end
    start = 1'b0;
    n_checks++; if (de != 33) begin n_errors++; $display("[TB] FAIL drop_done_edge: got %0d, expected 33", de); end
    n_checks++; if (hi !== exp[63:32]) begin n_errors++; $display("[TB] FAIL drop_hi: got %h, expected %h", hi, exp[63:32]); end
    n_checks++; if (lo !== exp[31:0]) begin n_errors++; $display("[TB] FAIL drop_lo: got %h, expected %h", lo, exp[31:0]); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) extra_done = 1'b1;
      if (busy) extra_busy = 1'b1;
    end
    n_checks++; if (extra_done !== 1'b0) begin n_errors++; $display("[TB] FAIL drop_queued_done: got %b, expected 0", extra_done); end
    n_checks++; if (extra_busy !== 1'b0) begin n_errors++; $display("[TB] FAIL drop_queued_busy: got %b, expected 0", extra_busy); end
    n_checks++; if (hi !== exp[63:32]) begin n_errors++; $display("[TB] FAIL drop_hi_after: got %h, expected %h", hi, exp[63:32]); end
    exp_hi = exp[63:32];
    exp_lo = exp[31:0];
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, h1, l1;
    logic [63:0] e1, e2;
    int          d1, d2;
    logic        busy2;
    a1 = $urandom;
    b1 = $urandom;
    a2 = $urandom;
    b2 = $urandom;
    e1 = model(F_MULTU, a1, b1, exp_hi, exp_lo);
    e2 = model(F_MULT, a2, b2, e1[63:32], e1[31:0]);
    d1 = -1;
    d2 = -1;
    busy2 = 1'b0;
    h1 = 32'd0;
    l1 = 32'd0;
    @(negedge clk);
    start = 1'b1;
    funct = F_MULTU;
    rs_data = a1;
    rt_data = b1;
    @(posedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (d1 < 0 && done) begin
        d1 = k;
        h1 = hi;
        l1 = lo;
        start = 1'b1;
        funct = F_MULT;
        rs_data = a2;
        rt_data = b2;
      end else if (d1 >= 0 && k == d1 + 1) begin
        start = 1'b0;
        busy2 = busy;
      end else if (d1 >= 0 && done) begin
        d2 = k;
        break;
      end
    end
    start = 1'b0;
    n_checks++; if (d1 != 33) begin n_errors++; $display("[TB] FAIL b2b_done1_edge: got %0d, expected 33", d1); end
    n_checks++; if (h1 !== e1[63:32]) begin n_errors++; $display("[TB] FAIL b2b_hi1: got %h, expected %h", h1, e1[63:32]); end
    n_checks++; if (l1 !== e1[31:0]) begin n_errors++; $display("[TB] FAIL b2b_lo1: got %h, expected %h", l1, e1[31:0]); end
    n_checks++; if (busy2 !== 1'b1) begin n_errors++; $display("[TB] FAIL b2b_accept_busy: got %b, expected 1", busy2); end
    n_checks++; if (d2 != 67) begin n_errors++; $display("[TB] FAIL b2b_done2_edge: got %0d, expected 67", d2); end
    n_checks++; if (hi !== e2[63:32]) begin n_errors++; $display("[TB] FAIL b2b_hi2: got %h, expected %h", hi, e2[63:32]); end
    n_checks++; if (lo !== e2[31:0]) begin n_errors++; $display("[TB] FAIL b2b_lo2: got %h, expected %h", lo, e2[31:0]); end
    exp_hi = e2[63:32];
    exp_lo = e2[31:0];
  endtask

  task automatic test_reset_abort();
    logic [31:0] h, l;
    int          bc, de;
    logic        dn, saw_done, saw_busy;
    logic [5:0]  abort_op;
`ifdef MULDIV_DIV_EN
    abort_op = F_DIV;
`else
    abort_op = F_MULT;
`endif
    run_op(F_MTHI, 32'hA5A5_A5A5, 32'd0, bc, de, dn, h, l);
    run_op(F_MTLO, 32'h5A5A_5A5A, 32'd0, bc, de, dn, h, l);
    saw_done = 1'b0;
    saw_busy = 1'b0;
    @(negedge clk);
    start = 1'b1;
    funct = abort_op;
    rs_data = $urandom;
    rt_data = $urandom | 32'd1;
    @(posedge clk);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (hi !== 32'd0) begin n_errors++; $display("[TB] FAIL abort_hi: got %h, expected %h", hi, 32'd0); end
    n_checks++; if (lo !== 32'd0) begin n_errors++; $display("[TB] FAIL abort_lo: got %h, expected %h", lo, 32'd0); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL abort_busy: got %b, expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("[TB] FAIL abort_done: got %b, expected 0", done); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_errors++; $display("[TB] FAIL abort_late_done: got %b, expected 0", saw_done); end
    n_checks++; if (saw_busy !== 1'b0) begin n_errors++; $display("[TB] FAIL abort_late_busy: got %b, expected 0", saw_busy); end
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    run_op(F_MULTU, 32'd3, 32'd4, bc, de, dn, h, l);
    n_checks++; if (l !== 32'd12) begin n_errors++; $display("[TB] FAIL post_abort_lo: got %h, expected %h", l, 32'd12); end
    n_checks++; if (h !== 32'd0) begin n_errors++; $display("[TB] FAIL post_abort_hi: got %h, expected %h", h, 32'd0); end
    n_checks++; if (de != 33) begin n_errors++; $display("[TB] FAIL post_abort_done_edge: got %0d, expected 33", de); end
    exp_hi = 32'd0;
    exp_lo = 32'd12;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_invalid_funct();
    test_busy_drop();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
